clink_param_streamer: RTL and testbench

//  Host-side transmitter for the Clink parameter-load interface. Stores NUM_SETS

---
 rtl/clink_param_streamer.sv | 151 +++++++++++++++
 tb/tb_clink_param_streamer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/clink_param_streamer.sv
// Host-side transmitter for the Clink parameter loader: holds NUM_SETS six-word
// parameter sets and streams a selected set as start pulse, w5..wb burst, commit.
module clink_param_streamer #(
    parameter int DW       = 16,
    parameter int NUM_SETS = 4,
    parameter int SET_W    = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [SET_W+2:0] cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,
    output logic             cfg_err,
    input  logic             load_req,
    input  logic [SET_W-1:0] load_sel,
    output logic             load_busy,
    output logic             load_done,
    input  logic             clink_busy,
    output logic             param_ld_start,
    output logic [DW-1:0]    param_ld_data,
    output logic             param_set
);

    // state  | meaning
    // IDLE   | waiting for load_req
    // START  | param_ld_start pulse
    // SEND   | six words, k = 5 down to 0
    // COMMIT | param_set once clink_busy is low
    // DONE   | load_done pulse
    typedef enum logic [2:0] {S_IDLE, S_START, S_SEND, S_COMMIT, S_DONE} state_t;

    localparam logic [SET_W:0] NSETS = (SET_W+1)'(NUM_SETS);

    state_t           state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [2:0]       k_q, k_d;
    logic [DW-1:0]    bank_q [NUM_SETS][6];
    logic [DW-1:0]    bank_d [NUM_SETS][6];

    logic             start_q, start_d;
    logic [DW-1:0]    data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [SET_W-1:0] wr_set;
    logic [2:0]       wr_word;
    logic             wr_ok;
    logic             req_err;

    assign wr_set  = cfg_addr[SET_W+2:3];
    assign wr_word = cfg_addr[2:0];

    // The set being streamed is write-protected from acceptance through DONE.
    always_comb begin
        wr_ok = cfg_we
              && ({1'b0, wr_set} < NSETS)
              && (wr_word < 3'd6)
              && !((state_q != S_IDLE) && (wr_set == set_q));
        bank_d = bank_q;
        if (wr_ok) begin
            bank_d[wr_set][wr_word] = cfg_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        k_d     = k_q;
        req_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    if ({1'b0, load_sel} < NSETS) begin
                        set_d   = load_sel;
                        state_d = S_START;
                    end else begin
                        req_err = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_SEND;
                k_d     = 3'd5;
            end
            S_SEND: begin
                if (k_q == 3'd0) begin
                    state_d = S_COMMIT;
                end else begin
                    k_d = k_q - 3'd1;
                end
            end
            S_COMMIT: begin
                if (!clink_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs are looked ahead from the next state so they line up with it.
    always_comb begin
        start_d = (state_d == S_START);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        err_d   = (cfg_we && !wr_ok) || req_err;
        data_d  = '0;
        if (state_d == S_SEND) begin
            data_d = bank_q[set_d][k_d];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            k_q     <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < 6; w++) begin
                    bank_q[s][w] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            k_q     <= k_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bank_q  <= bank_d;
        end
    end

    assign param_ld_start = start_q;
    assign param_ld_data  = data_q;
    assign load_busy      = busy_q;
    assign load_done      = done_q;
    assign cfg_err        = err_q;
    // Commit must track clink_busy in the same cycle, so it is gated from the state register.
    assign param_set      = (state_q == S_COMMIT) && !clink_busy;

endmodule

// File: tb/tb_clink_param_streamer.sv
// Directed + randomized bench for clink_param_streamer with a behavioural bank
// model and a receiver shift-chain scoreboard.
module tb_clink_param_streamer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        cfg_err;
    logic        load_req;
    logic [1:0]  load_sel;
    logic        load_busy;
    logic        load_done;
    logic        clink_busy;
    logic        param_ld_start;
    logic [15:0] param_ld_data;
    logic        param_set;

    clink_param_streamer #(.DW(16), .NUM_SETS(4), .SET_W(2)) dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
        .load_req(load_req), .load_sel(load_sel), .load_busy(load_busy), .load_done(load_done),
        .clink_busy(clink_busy), .param_ld_start(param_ld_start),
        .param_ld_data(param_ld_data), .param_set(param_set)
    );

    always #5 clock = ~clock;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] mbank [4][6];
    logic        err_next = 1'b0;
    logic        err_exp  = 1'b0;
    logic        m_busy   = 1'b0;
    logic [1:0]  m_set    = 2'd0;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        cfg_we   = 1'b0;
        load_req = 1'b0;
        err_exp  = err_next;
        err_next = 1'b0;
    endtask

    task automatic sample();
        @(negedge clock);
        chk("cfg_err", cfg_err, err_exp);
    endtask

    task automatic chk_o(input string t, input logic st, input logic [15:0] d,
                         input logic ps, input logic bz, input logic dn);
        chk({t, ".start"}, param_ld_start, st);
        chk({t, ".data"},  param_ld_data,  d);
        chk({t, ".set"},   param_set,      ps);
        chk({t, ".busy"},  load_busy,      bz);
        chk({t, ".done"},  load_done,      dn);
    endtask

    // Model of the write acceptance rule; updates the model bank immediately.
    task automatic wr(input logic [1:0] s, input logic [2:0] w, input logic [15:0] d);
        logic ok;
        ok        = (w < 3'd6) && !(m_busy && s == m_set);
        cfg_we    = 1'b1;
        cfg_addr  = {s, w};
        cfg_wdata = d;
        if (ok) mbank[s][w] = d;
        err_next  = !ok;
    endtask

    // Entered right after cyc(): requests set sel, checks every cycle to the IDLE cycle after DONE.
    task automatic run_load(input logic [1:0] sel, input int nbusy, input int wr_at,
                            input logic [1:0] ws, input logic [2:0] ww, input logic [15:0] wd);
        logic [15:0] exp_w [6];
        load_req = 1'b1;
        load_sel = sel;
        for (int j = 0; j < 6; j++) exp_w[j] = mbank[sel][j];
        sample();
        chk_o("req", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        m_busy = 1'b1;
        m_set  = sel;
        sample();
        chk_o("start", 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 2) begin
                load_req = 1'b1;
                load_sel = 2'($urandom_range(0, 3));
            end
            if (i == wr_at) wr(ws, ww, wd);
            sample();
            chk_o("send", 1'b0, exp_w[5-i], 1'b0, 1'b1, 1'b0);
        end
        for (int b = 0; b < nbusy; b++) begin
            cyc();
            clink_busy = 1'b1;
            sample();
            chk_o("hold", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        end
        cyc();
        clink_busy = 1'b0;
        sample();
        chk_o("commit", 1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        cyc();
        sample();
        chk_o("done", 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
        m_busy = 1'b0;
        cyc();
        sample();
        chk_o("idle", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Receiver shift chain: the last word shifted in lands in wb (index 0).
    int          sb_cnt = 0;
    logic [15:0] cap [6];
    always @(negedge clock) begin
        logic [95:0] got, want;
        if (reset) begin
            sb_cnt = 0;
        end else begin
            if (sb_cnt > 0) begin
                for (int i = 5; i > 0; i--) cap[i] = cap[i-1];
                cap[0] = param_ld_data;
                sb_cnt--;
            end
            if (param_ld_start) sb_cnt = 6;
            if (param_set) begin
                for (int i = 0; i < 6; i++) begin
                    got[i*16 +: 16]  = cap[i];
                    want[i*16 +: 16] = mbank[m_set][i];
                end
                chk("scoreboard", got, want);
            end
        end
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        load_req = 1'b0; load_sel = '0; clink_busy = 1'b0;
        for (int s = 0; s < 4; s++) for (int w = 0; w < 6; w++) mbank[s][w] = 16'h0;
        cyc();
        cyc();
        sample();
        chk_o("reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Fill the bank: set1 fixed, others random.
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 6; w++) begin
                cyc();
                wr(2'(s), 3'(w), (s == 1) ? 16'(16'h0010 + w) : 16'($urandom));
                sample();
            end
        end
        cyc(); wr(2'd2, 3'd6, 16'h1234); sample();
        cyc(); wr(2'd0, 3'd7, 16'h5678); sample();
        cyc(); sample();

        // Basic stream, then commit held off by clink_busy.
        cyc(); run_load(2'd1, 0, -1, 2'd0, 3'd0, 16'h0);
        cyc(); run_load(2'd1, 5, -1, 2'd0, 3'd0, 16'h0);
        // Write to the streaming set is rejected; write to another set is accepted.
        cyc(); run_load(2'd1, 0, 1, 2'd1, 3'd3, 16'hDEAD);
        cyc(); run_load(2'd1, 1, 3, 2'd2, 3'd0, 16'hBEEF);
        cyc(); run_load(2'd2, 0, -1, 2'd0, 3'd0, 16'h0);
        // Invalid word field during a burst.
        cyc(); run_load(2'd0, 2, 4, 2'd3, 3'd6, 16'h7777);
        // Write and request in the same IDLE cycle: the new word is streamed.
        cyc(); wr(2'd3, 3'd5, 16'hA5A5); run_load(2'd3, 0, -1, 2'd0, 3'd0, 16'h0);

        for (int n = 0; n < 8; n++) begin
            cyc();
            run_load(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 16'($urandom));
        end

        // Reset during the third data word aborts the burst and clears the bank.
        cyc(); load_req = 1'b1; load_sel = 2'd1; sample();
        cyc(); m_busy = 1'b1; m_set = 2'd1; sample();
        chk("abort.start", param_ld_start, 1'b1);
        cyc(); sample(); chk("abort.w5", param_ld_data, mbank[1][5]);
        cyc(); sample(); chk("abort.w4", param_ld_data, mbank[1][4]);
        cyc(); reset = 1'b1; sample(); chk("abort.w3", param_ld_data, mbank[1][3]);
        cyc(); reset = 1'b0; sample();
        for (int s = 0; s < 4; s++) for (int w = 0; w < 6; w++) mbank[s][w] = 16'h0;
        m_busy = 1'b0;
        chk_o("post_rst", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(); sample();
            chk_o("quiet", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        cyc(); run_load(2'd1, 0, -1, 2'd0, 3'd0, 16'h0);
        cyc(); run_load(2'd3, 1, -1, 2'd0, 3'd0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
